// File: rtl/logic_gate_unit.sv
// Registered WIDTH-bit two-operand logic unit with optional packet folding behind valid/ready.
// Optional output parity_o is enabled by defining LOGIC_GATE_UNIT_PARITY_EN.
module logic_gate_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [2:0]       op_i,
  input  logic             acc_en_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             last_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [WIDTH-1:0] c_o,
`ifdef LOGIC_GATE_UNIT_PARITY_EN
  output logic             parity_o,
`endif
  output logic [CNT_W-1:0] count_o,
  output logic             valid_o,
  input  logic             ready_i
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_e;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_ANDN = 3'd6;

  function automatic logic [WIDTH-1:0] apply_op(input logic [2:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    case (op)
      OP_AND:  apply_op = a & b;
      OP_OR:   apply_op = a | b;
      OP_XOR:  apply_op = a ^ b;
      OP_NAND: apply_op = ~(a & b);
      OP_NOR:  apply_op = ~(a | b);
      OP_XNOR: apply_op = ~(a ^ b);
      OP_ANDN: apply_op = a & ~b;
      default: apply_op = a;
    endcase
  endfunction

  // Inverting ops fold with their base operator; PASS_A keeps the newest beat.
  function automatic logic [WIDTH-1:0] fold_op(input logic [2:0] op,
                                               input logic [WIDTH-1:0] acc,
                                               input logic [WIDTH-1:0] r);
    case (op)
      OP_AND, OP_NAND, OP_ANDN: fold_op = acc & r;
      OP_OR, OP_NOR:            fold_op = acc | r;
      OP_XOR, OP_XNOR:          fold_op = acc ^ r;
      default:                  fold_op = r;
    endcase
  endfunction

  function automatic logic even_parity(input logic [WIDTH-1:0] v);
    even_parity = ^v;
  endfunction

  state_e           state_r, state_n_s;
  logic [WIDTH-1:0] acc_r, acc_n_s;
  logic [CNT_W-1:0] cnt_r, cnt_n_s;
  logic [2:0]       op_lat_r, op_lat_n_s;
  logic [WIDTH-1:0] c_r, c_n_s;
  logic [CNT_W-1:0] count_r, count_n_s;
  logic             valid_r, valid_n_s;
  logic             ready_s, accept_s;
  logic [2:0]       eff_op_s;
  logic [WIDTH-1:0] r_s, fold_s;
  logic [CNT_W-1:0] cnt_inc_s;
`ifdef LOGIC_GATE_UNIT_PARITY_EN
  logic             par_r, par_n_s;
`endif

  assign ready_s   = !valid_r || ready_i;
  assign accept_s  = valid_i && ready_s;
  assign eff_op_s  = (state_r == ST_ACCUM) ? op_lat_r : op_i;
  assign r_s       = apply_op(eff_op_s, a_i, b_i);
  assign fold_s    = fold_op(op_lat_r, acc_r, r_s);
  assign cnt_inc_s = (cnt_r == {CNT_W{1'b1}}) ? cnt_r : cnt_r + CNT_W'(1);

  // Next-state, accumulator and output-register load decisions.
  always_comb begin
    state_n_s  = state_r;
    acc_n_s    = acc_r;
    cnt_n_s    = cnt_r;
    op_lat_n_s = op_lat_r;
    c_n_s      = c_r;
    count_n_s  = count_r;
    if (valid_r && ready_i) begin
      valid_n_s = 1'b0;
    end else begin
      valid_n_s = valid_r;
    end
    if (accept_s) begin
      case (state_r)
        ST_IDLE: begin
          if (!acc_en_i || last_i) begin
            c_n_s     = r_s;
            count_n_s = CNT_W'(1);
            valid_n_s = 1'b1;
          end else begin
            acc_n_s    = r_s;
            cnt_n_s    = CNT_W'(1);
            op_lat_n_s = op_i;
            state_n_s  = ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (!last_i) begin
            acc_n_s = fold_s;
            cnt_n_s = cnt_inc_s;
          end else begin
            c_n_s     = fold_s;
            count_n_s = cnt_inc_s;
            valid_n_s = 1'b1;
            acc_n_s   = {WIDTH{1'b0}};
            cnt_n_s   = {CNT_W{1'b0}};
            state_n_s = ST_IDLE;
          end
        end
        default: state_n_s = ST_IDLE;
      endcase
    end else begin
      state_n_s = state_r;
    end
`ifdef LOGIC_GATE_UNIT_PARITY_EN
    par_n_s = even_parity(c_n_s);
`endif
  end

  // State, accumulator and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r  <= ST_IDLE;
      acc_r    <= {WIDTH{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      op_lat_r <= 3'd0;
      c_r      <= {WIDTH{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      valid_r  <= 1'b0;
`ifdef LOGIC_GATE_UNIT_PARITY_EN
      par_r    <= 1'b0;
`endif
    end else begin
      state_r  <= state_n_s;
      acc_r    <= acc_n_s;
      cnt_r    <= cnt_n_s;
      op_lat_r <= op_lat_n_s;
      c_r      <= c_n_s;
      count_r  <= count_n_s;
      valid_r  <= valid_n_s;
`ifdef LOGIC_GATE_UNIT_PARITY_EN
      par_r    <= par_n_s;
`endif
    end
  end

  assign ready_o = ready_s;
  assign c_o     = c_r;
  assign count_o = count_r;
  assign valid_o = valid_r;
`ifdef LOGIC_GATE_UNIT_PARITY_EN
  assign parity_o = par_r;
`endif

endmodule

// File: tb/tb_logic_gate_unit.sv
// Self-checking bench for logic_gate_unit: directed scenarios plus randomized traffic
// checked against a packet-level reference model.
module tb_logic_gate_unit;

  logic       clk;
  logic       rst_ni;
  logic [2:0] op_i;
  logic       acc_en_i;
  logic [7:0] a_i, b_i;
  logic       last_i, valid_i, ready_i;
  logic       ready_o, valid_o;
  logic [7:0] c_o;
  logic [3:0] count_o;
`ifdef LOGIC_GATE_UNIT_PARITY_EN
  logic       parity_o;
`endif

  int checks = 0;
  int errors = 0;

  // reference model state: output register contents and the open packet's beats
  bit         m_valid;
  logic [7:0] m_c;
  logic [3:0] m_cnt;
  bit         m_open;
  logic [2:0] m_op;
  logic [7:0] m_beats[$];
  logic       obs_ready, exp_ready;

  logic_gate_unit #(.WIDTH(8), .CNT_W(4)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .op_i(op_i), .acc_en_i(acc_en_i),
    .a_i(a_i), .b_i(b_i), .last_i(last_i), .valid_i(valid_i),
    .ready_o(ready_o), .c_o(c_o),
`ifdef LOGIC_GATE_UNIT_PARITY_EN
    .parity_o(parity_o),
`endif
    .count_o(count_o), .valid_o(valid_o), .ready_i(ready_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] beat_r(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a & b);
      3'd4: return ~(a | b);
      3'd5: return ~(a ^ b);
      3'd6: return a & ~b;
      default: return a;
    endcase
  endfunction

  // Per-bit view of a whole packet: count how many beats have each bit set.
  function automatic logic [7:0] pkt_fold(input logic [2:0] op);
    logic [7:0] res;
    int n, ones;
    n = m_beats.size();
    for (int k = 0; k < 8; k++) begin
      ones = 0;
      foreach (m_beats[j]) ones += int'(m_beats[j][k]);
      case (op)
        3'd0, 3'd3, 3'd6: res[k] = (ones == n);
        3'd1, 3'd4:       res[k] = (ones != 0);
        3'd2, 3'd5:       res[k] = ones[0];
        default:          res[k] = m_beats[n-1][k];
      endcase
    end
    return res;
  endfunction

  function automatic void model_reset();
    m_valid = 1'b0; m_c = 8'h00; m_cnt = 4'd0; m_open = 1'b0; m_beats.delete();
  endfunction

  // Drive one cycle of stimulus, advance the model, end on the following negedge.
  task automatic cycle(input logic v, input logic [2:0] op, input logic acc, input logic [7:0] a,
                       input logic [7:0] b, input logic last, input logic rdy);
    logic accept, produce;
    valid_i = v; op_i = op; acc_en_i = acc; a_i = a; b_i = b; last_i = last; ready_i = rdy;
    #1;
    obs_ready = ready_o;
    exp_ready = !m_valid || rdy;
    accept = v && exp_ready;
    produce = 1'b0;
    if (accept) begin
      if (!m_open) begin
        if (!acc || last) begin
          m_c = beat_r(op, a, b); m_cnt = 4'd1; produce = 1'b1;
        end else begin
          m_open = 1'b1; m_op = op; m_beats.delete(); m_beats.push_back(beat_r(op, a, b));
        end
      end else begin
        m_beats.push_back(beat_r(m_op, a, b));
        if (last) begin
          m_c = pkt_fold(m_op);
          m_cnt = (m_beats.size() > 15) ? 4'd15 : 4'(m_beats.size());
          produce = 1'b1; m_open = 1'b0; m_beats.delete();
        end
      end
    end
    if (produce) m_valid = 1'b1;
    else if (rdy) m_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    #2 rst_ni = 1'b0;
    model_reset();
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; valid_i = 1'b0; op_i = 3'd0; acc_en_i = 1'b0;
    a_i = 8'h00; b_i = 8'h00; last_i = 1'b0; ready_i = 1'b0;
    model_reset();
    #2;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid_o); end
    checks++; if (c_o !== 8'h00) begin errors++; $display("FAIL reset_c got %h want 00", c_o); end
    checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count_o); end
    @(negedge clk); @(negedge clk);
    rst_ni = 1'b1;
    #1;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready_o); end
    @(negedge clk);
  endtask

  task automatic test_single_and();
    cycle(1'b1, 3'd0, 1'b0, 8'hF0, 8'h3C, 1'b0, 1'b1);
    checks++; if (valid_o !== 1'b1 || c_o !== 8'h30 || count_o !== 4'd1) begin
      errors++; $display("FAIL single_and got v=%b c=%h n=%0d want v=1 c=30 n=1", valid_o, c_o, count_o); end
`ifdef LOGIC_GATE_UNIT_PARITY_EN
    checks++; if (parity_o !== 1'b0) begin errors++; $display("FAIL parity_30 got %b want 0", parity_o); end
`endif
    cycle(1'b0, 3'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    checks++; if (valid_o !== 1'b0 || c_o !== 8'h30) begin
      errors++; $display("FAIL single_and_drop got v=%b c=%h want v=0 c=30", valid_o, c_o); end
  endtask

  task automatic test_and_fold();
    cycle(1'b1, 3'd0, 1'b1, 8'hFF, 8'hF7, 1'b0, 1'b1);
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL and_fold_b1 got v=%b want 0", valid_o); end
    cycle(1'b1, 3'd0, 1'b1, 8'hFE, 8'hFF, 1'b0, 1'b1);
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL and_fold_b2 got v=%b want 0", valid_o); end
    cycle(1'b1, 3'd0, 1'b1, 8'h7F, 8'hFF, 1'b1, 1'b1);
    checks++; if (valid_o !== 1'b1 || c_o !== 8'h76 || count_o !== 4'd3) begin
      errors++; $display("FAIL and_fold got v=%b c=%h n=%0d want v=1 c=76 n=3", valid_o, c_o, count_o); end
`ifdef LOGIC_GATE_UNIT_PARITY_EN
    checks++; if (parity_o !== 1'b1) begin errors++; $display("FAIL parity_76 got %b want 1", parity_o); end
`endif
    cycle(1'b0, 3'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_xor_fold_op_change();
    cycle(1'b1, 3'd2, 1'b1, 8'h0F, 8'h00, 1'b0, 1'b1);
    cycle(1'b1, 3'd0, 1'b0, 8'hF0, 8'h00, 1'b1, 1'b1);
    checks++; if (valid_o !== 1'b1 || c_o !== 8'hFF || count_o !== 4'd2) begin
      errors++; $display("FAIL xor_fold got v=%b c=%h n=%0d want v=1 c=ff n=2", valid_o, c_o, count_o); end
    cycle(1'b0, 3'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_back_pressure();
    cycle(1'b1, 3'd0, 1'b0, 8'hF0, 8'h3C, 1'b0, 1'b0);
    cycle(1'b1, 3'd0, 1'b0, 8'h0F, 8'hFF, 1'b0, 1'b0);
    checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL bp_ready got %b want 0", obs_ready); end
    checks++; if (valid_o !== 1'b1 || c_o !== 8'h30 || count_o !== 4'd1) begin
      errors++; $display("FAIL bp_hold got v=%b c=%h n=%0d want v=1 c=30 n=1", valid_o, c_o, count_o); end
    cycle(1'b1, 3'd0, 1'b0, 8'h0F, 8'hFF, 1'b0, 1'b1);
    checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b want 1", obs_ready); end
    checks++; if (valid_o !== 1'b1 || c_o !== 8'h0F) begin
      errors++; $display("FAIL bp_second got v=%b c=%h want v=1 c=0f", valid_o, c_o); end
    cycle(1'b0, 3'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL bp_drain got v=%b want 0", valid_o); end
  endtask

  task automatic test_reset_mid_packet();
    cycle(1'b1, 3'd0, 1'b1, 8'hFF, 8'h0F, 1'b0, 1'b1);
    cycle(1'b1, 3'd0, 1'b1, 8'h3F, 8'hFF, 1'b0, 1'b1);
    pulse_reset();
    checks++; if (valid_o !== 1'b0 || c_o !== 8'h00) begin
      errors++; $display("FAIL rst_mid_clear got v=%b c=%h want v=0 c=00", valid_o, c_o); end
    cycle(1'b1, 3'd0, 1'b0, 8'hAA, 8'hFF, 1'b0, 1'b1);
    checks++; if (valid_o !== 1'b1 || c_o !== 8'hAA || count_o !== 4'd1) begin
      errors++; $display("FAIL rst_mid_fresh got v=%b c=%h n=%0d want v=1 c=aa n=1", valid_o, c_o, count_o); end
    cycle(1'b0, 3'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++)
      cycle(1'b1, 3'd1, 1'b1, 8'($urandom) & 8'h11, 8'($urandom) & 8'h22, (i == 19), 1'b1);
    checks++; if (valid_o !== 1'b1 || count_o !== 4'd15 || c_o !== m_c) begin
      errors++; $display("FAIL saturation got v=%b c=%h n=%0d want v=1 c=%h n=15", valid_o, c_o, count_o, m_c); end
    cycle(1'b0, 3'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if (i == 300) pulse_reset();
      cycle($urandom_range(0, 3) != 0, 3'($urandom), $urandom_range(0, 3) != 0, 8'($urandom),
            8'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0);
      checks++; if (obs_ready !== exp_ready) begin
        errors++; $display("FAIL rand_ready cyc %0d got %b want %b", i, obs_ready, exp_ready); end
      checks++; if (valid_o !== m_valid || c_o !== m_c || count_o !== m_cnt) begin
        errors++; $display("FAIL rand_out cyc %0d got v=%b c=%h n=%0d want v=%b c=%h n=%0d",
                           i, valid_o, c_o, count_o, m_valid, m_c, m_cnt); end
`ifdef LOGIC_GATE_UNIT_PARITY_EN
      checks++; if (parity_o !== ^m_c) begin
        errors++; $display("FAIL rand_parity cyc %0d got %b want %b", i, parity_o, ^m_c); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_single_and();
    test_and_fold();
    test_xor_fold_op_change();
    test_back_pressure();
    test_reset_mid_packet();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
